// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared defaults, FSM states and request type for the register bus mover
package reg_bus_pkg;

    localparam int DATA_W_DEF   = 20;
    localparam int NUM_REGS_DEF = 8;
    localparam int IDX_W_DEF    = $clog2(NUM_REGS_DEF);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    typedef struct packed {
        logic                  imm;
        logic [IDX_W_DEF-1:0]  src;
        logic [IDX_W_DEF-1:0]  dst;
        logic [DATA_W_DEF-1:0] data;
    } req_t;

endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - gated index to one-hot decoder; indices past NUM_OUT assert nothing
module onehot_decoder #(
    parameter int IDX_W   = 3,
    parameter int NUM_OUT = 8
) (
    input  logic               en,
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_OUT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (en && (int'(idx) == i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bus_mover.sv
// rtl/reg_bus_mover.sv - register bus master for moves and immediate loads; optional RANGE_CHECK_EN adds err
module reg_bus_mover
    import reg_bus_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_imm,
    input  logic [IDX_W-1:0]    req_src,
    input  logic [IDX_W-1:0]    req_dst,
    input  logic [DATA_W-1:0]   req_data,
    input  logic [DATA_W-1:0]   bus_in,
    output logic [DATA_W-1:0]   bus_out,
    output logic                bus_oe,
    output logic [NUM_REGS-1:0] en_read,
    output logic [NUM_REGS-1:0] en_write,
    output logic                busy,
    output logic                done
`ifdef RANGE_CHECK_EN
    ,
    output logic                err
`endif
);

    state_t              state, state_d;
    logic [IDX_W-1:0]    dst_q, dst_d, wr_idx;
    logic [DATA_W-1:0]   hold, hold_d, bus_out_d;
    logic                rd_en, wr_en, bus_oe_d, done_d;
    logic                accept, reject;
    logic [NUM_REGS-1:0] rd_oh, wr_oh;

    assign accept = req_valid && (state == IDLE);

`ifdef RANGE_CHECK_EN
    assign reject = (int'(req_dst) >= NUM_REGS) ||
                    (!req_imm && (int'(req_src) >= NUM_REGS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= accept && reject;
    end
`else
    assign reject = 1'b0;
`endif

    // Next-cycle outputs are decoded here and registered below, so enables
    // are already stable when the bank samples on the falling edge.
    always_comb begin
        state_d   = state;
        dst_d     = dst_q;
        hold_d    = hold;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = dst_q;
        bus_out_d = '0;
        bus_oe_d  = 1'b0;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !reject) begin
                    dst_d = req_dst;
                    if (req_imm) begin
                        state_d   = WRITE;
                        hold_d    = req_data;
                        wr_en     = 1'b1;
                        wr_idx    = req_dst;
                        bus_out_d = req_data;
                        bus_oe_d  = 1'b1;
                    end else begin
                        state_d = READ;
                        rd_en   = 1'b1;
                    end
                end
            end
            READ: begin
                state_d   = WRITE;
                hold_d    = bus_in;
                wr_en     = 1'b1;
                bus_out_d = bus_in;
                bus_oe_d  = 1'b1;
            end
            WRITE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    onehot_decoder #(.IDX_W(IDX_W), .NUM_OUT(NUM_REGS)) u_rd_dec (
        .en     (rd_en),
        .idx    (req_src),
        .onehot (rd_oh)
    );

    onehot_decoder #(.IDX_W(IDX_W), .NUM_OUT(NUM_REGS)) u_wr_dec (
        .en     (wr_en),
        .idx    (wr_idx),
        .onehot (wr_oh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dst_q     <= '0;
            hold      <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            en_read   <= '0;
            en_write  <= '0;
            bus_oe    <= 1'b0;
            bus_out   <= '0;
        end else begin
            state     <= state_d;
            dst_q     <= dst_d;
            hold      <= hold_d;
            req_ready <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            done      <= done_d;
            en_read   <= rd_oh;
            en_write  <= wr_oh;
            bus_oe    <= bus_oe_d;
            bus_out   <= bus_out_d;
        end
    end

endmodule

// File: tb/tb_reg_bus_mover.sv
// tb/tb_reg_bus_mover.sv - randomized bench with transaction-level model and register bank for reg_bus_mover
module tb_reg_bus_mover;
    import reg_bus_pkg::*;

    localparam int DW = 20;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0, req_imm = 1'b0;
    logic [2:0]    req_src = '0, req_dst = '0;
    logic [DW-1:0] req_data = '0;
    logic          req_ready, bus_oe, busy, done;
    logic [DW-1:0] bus_in, bus_out;
    logic [NR-1:0] en_read, en_write;
`ifdef RANGE_CHECK_EN
    logic          err;
`endif

    reg_bus_mover dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_imm(req_imm), .req_src(req_src), .req_dst(req_dst), .req_data(req_data),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .en_read(en_read),
        .en_write(en_write), .busy(busy), .done(done)
`ifdef RANGE_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register bank: tristate bus resolved in the bench, writes on falling edge.
    logic [DW-1:0] bank [NR];
    logic [DW-1:0] rd_val;
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NR; i++) if (en_read[i]) rd_val = bank[i];
    end
    assign bus_in = bus_oe ? bus_out : rd_val;

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) if (en_write[i]) bank[i] = bus_in;
    end

    // Transaction model: expectations keyed by cycle number.
    logic [DW-1:0] m_reg [NR];
    int cyc = 0;
    int busy_end = -1;
    logic [NR-1:0] e_rd [int];
    logic [NR-1:0] e_wr [int];
    logic [DW-1:0] e_bo [int];
    bit            e_done [int];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_rd.delete(); e_wr.delete(); e_bo.delete(); e_done.delete();
            busy_end = cyc - 1;
        end else begin
            cyc++;
            if (req_valid && (cyc - 1 > busy_end)) begin
                if (req_imm) begin
                    e_wr[cyc]     = NR'(1) << req_dst;
                    e_bo[cyc]     = req_data;
                    e_done[cyc+1] = 1'b1;
                    busy_end      = cyc;
                end else begin
                    e_rd[cyc]     = NR'(1) << req_src;
                    e_wr[cyc+1]   = NR'(1) << req_dst;
                    e_bo[cyc+1]   = m_reg[req_src];
                    e_done[cyc+2] = 1'b1;
                    busy_end      = cyc + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", req_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_en_read", en_read, 0);
            chk("rst_en_write", en_write, 0);
            chk("rst_bus_oe", bus_oe, 0);
            chk("rst_bus_out", bus_out, 0);
        end else begin
            logic [NR-1:0] xr, xw;
            bit xd;
            xr = e_rd.exists(cyc) ? e_rd[cyc] : '0;
            xw = e_wr.exists(cyc) ? e_wr[cyc] : '0;
            xd = e_done.exists(cyc) ? e_done[cyc] : 1'b0;
            chk("en_read", en_read, xr);
            chk("en_write", en_write, xw);
            chk("bus_oe", bus_oe, (xw != 0));
            if (xw != 0) begin
                chk("bus_out", bus_out, e_bo[cyc]);
                for (int i = 0; i < NR; i++) if (xw[i]) m_reg[i] = e_bo[cyc];
            end
            chk("done", done, xd);
            chk("req_ready", req_ready, (cyc > busy_end));
            chk("busy", busy, !(cyc > busy_end));
            chk("no_contention", (en_read != 0) && bus_oe, 0);
            chk("onehot", ($countones(en_read) <= 1) && ($countones(en_write) <= 1), 1);
`ifdef RANGE_CHECK_EN
            chk("err", err, 0);
`endif
            if (done) done_cnt++;
        end
    end

    task automatic send(input logic imm, input logic [2:0] src, input logic [2:0] dst,
                        input logic [DW-1:0] data, output time t_acc);
        bit acc;
        int n;
        #1;
        req_imm = imm; req_src = src; req_dst = dst; req_data = data; req_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        do begin
            @(posedge clk);
            acc = req_ready;
            n++;
        end while (!acc && n < 20);
        if (!acc) chk("accept_timeout", 0, 1);
        t_acc = $time;
    endtask

    time t0, ta [4];
    int  dc0;
    req_t rq;

    initial begin
        for (int i = 0; i < NR; i++) begin
            bank[i]  = DW'(i * 32'h1111);
            m_reg[i] = DW'(i * 32'h1111);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("lit_reset_ready", req_ready, 1);

        // Immediate load
        send(1, 0, 5, 20'hABCDE, t0);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("lit_imm_en_write", en_write, 8'h20);
        chk("lit_imm_bus_out", bus_out, 20'hABCDE);
        @(negedge clk);
        chk("lit_imm_done", done, 1);

        // Move R2 -> R7
        send(1, 0, 2, 20'h12345, t0);
        send(0, 2, 7, 20'h0, t0);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("lit_mv_en_read", en_read, 8'h04);
        @(negedge clk);
        chk("lit_mv_en_write", en_write, 8'h80);
        chk("lit_mv_bus_out", bus_out, 20'h12345);
        @(negedge clk);
        chk("lit_mv_done", done, 1);

        // Self-move
        send(1, 0, 3, 20'h0F0F0, t0);
        send(0, 3, 3, 20'h0, t0);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("lit_self_r3", bank[3], 20'h0F0F0);

        // Back-to-back with valid held high
        dc0 = done_cnt;
        for (int i = 0; i < 4; i++) send(1, 0, 3'(i), DW'(32'h10000 + i), ta[i]);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 1; i < 4; i++) chk("lit_b2b_spacing", 32'(ta[i] - ta[i-1]), 20);
        chk("lit_b2b_dones", done_cnt - dc0, 4);

        // Async reset in the middle of a write
        dc0 = done_cnt;
        send(1, 0, 6, 20'h55555, t0);
        #1 req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("lit_rst_en_write", en_write, 0);
        chk("lit_rst_bus_oe", bus_oe, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("lit_rst_ready_after", req_ready, 1);
        repeat (3) @(negedge clk);
        chk("lit_rst_no_done", done_cnt - dc0, 0);
        chk("lit_rst_r6_kept", bank[6], 20'h06666);

        // Randomized traffic
        repeat (400) begin
            @(posedge clk);
            #1;
            rq = req_t'({$urandom, $urandom});
            req_valid = ($urandom_range(0, 1) == 1);
            req_imm = rq.imm; req_src = rq.src; req_dst = rq.dst; req_data = rq.data;
        end
        #1 req_valid = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < NR; i++) chk("bank_final", bank[i], m_reg[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
